// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, ALU codes,
// FSM states and datapath mux selects.
package riscv_ctrl_pkg;

   localparam int CTRL_STATE_W = 4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctrl_e;

   typedef enum logic [CTRL_STATE_W-1:0] {
      S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_TRAP
   } state_e;

   typedef enum logic [1:0] {OPC_ADD, OPC_SUB, OPC_R, OPC_I} op_class_e;

   typedef enum logic {ADR_PC = 1'b0, ADR_ALUOUT = 1'b1} adr_src_e;
   typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} src_a_e;
   typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} src_b_e;
   typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MDR = 2'b01, RES_ALU = 2'b10} result_src_e;

   // funct3 values the ALU actually implements (no shifts, no SLTU)
   function automatic logic funct3_ok(input logic [2:0] f3);
      return f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an operation class plus funct3/funct7b5 to an ALU control code and
// flags encodings the ALU cannot execute.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  op_class_e  op_class,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output alu_ctrl_e  alu_control,
   output logic       legal
);

   always_comb begin
      alu_control = ALU_ADD;
      legal       = 1'b1;
      case (op_class)
         OPC_ADD: alu_control = ALU_ADD;
         OPC_SUB: alu_control = ALU_SUB;
         default: begin
            // bit 30 only selects SUB on R-type; on I-type it is an immediate bit we refuse
            legal = funct3_ok(funct3) && !(op_class == OPC_I && funct7b5);
            case (funct3)
               3'b000:  alu_control = (op_class == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b100:  alu_control = ALU_XOR;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and ALU, with a memory wait timeout and sticky traps.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int STATE_W        = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               adr_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         result_src,
   output logic [3:0]         alu_control,
   output logic               instr_done,
   output logic               illegal,
   output logic               bus_error,
   output logic [STATE_W-1:0] state
);

   localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TMAX   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_e            st, nxt;
   logic [WCNT_W-1:0] wcnt;
   logic              waiting, timeout;
   op_class_e         op_class;
   alu_ctrl_e         dec_alu;
   logic              dec_legal;

   assign state   = STATE_W'(st);
   assign waiting = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);
   // wcnt counts earlier wait cycles, so this fires on the TIMEOUT_CYCLES-th one
   assign timeout = (TIMEOUT_CYCLES != 0) && waiting && !mem_ready &&
                    (wcnt == WCNT_W'(TMAX));

   always_comb begin
      if (st == S_BEQ)            op_class = OPC_SUB;
      else if (opcode == OP_RTYPE) op_class = OPC_R;
      else if (opcode == OP_ITYPE) op_class = OPC_I;
      else                         op_class = OPC_ADD;
   end

   alu_decoder u_alu_dec (
      .op_class    (op_class),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_control (dec_alu),
      .legal       (dec_legal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= S_RESET;
      else     st <= nxt;
   end

   always_comb begin
      nxt = st;
      case (st)
         S_RESET:    nxt = S_FETCH;
         S_FETCH:    if (mem_ready) nxt = S_DECODE; else if (timeout) nxt = S_TRAP;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_RTYPE:          nxt = dec_legal ? S_EXECR : S_TRAP;
               OP_ITYPE:          nxt = dec_legal ? S_EXECI : S_TRAP;
               OP_BRANCH:         nxt = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
               default:           nxt = S_TRAP;
            endcase
         end
         S_MEMADR:   nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) nxt = S_MEMWB; else if (timeout) nxt = S_TRAP;
         S_MEMWB:    nxt = S_FETCH;
         S_MEMWRITE: if (mem_ready) nxt = S_FETCH; else if (timeout) nxt = S_TRAP;
         S_EXECR,
         S_EXECI:    nxt = S_ALUWB;
         S_ALUWB,
         S_BEQ:      nxt = S_FETCH;
         S_TRAP:     nxt = S_TRAP;
         default:    nxt = S_RESET;
      endcase
   end

   // leaving a state clears the counter, so every wait state starts from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                              wcnt <= '0;
      else if (nxt != st)                                   wcnt <= '0;
      else if (waiting && !mem_ready && TIMEOUT_CYCLES != 0) wcnt <= wcnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal   <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         if (st == S_DECODE && nxt == S_TRAP) illegal   <= 1'b1;
         if (timeout)                         bus_error <= 1'b1;
      end
   end

   always_comb begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      adr_src     = ADR_PC;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      result_src  = RES_ALUOUT;
      alu_control = ALU_AND;
      instr_done  = 1'b0;
      case (st)
         S_FETCH: begin
            mem_read    = 1'b1;
            alu_src_b   = SRCB_FOUR;
            alu_control = ALU_ADD;
            result_src  = RES_ALU;
            ir_write    = mem_ready;
            pc_write    = mem_ready;
         end
         S_DECODE: begin
            alu_src_a   = SRCA_OLDPC;
            alu_src_b   = SRCB_IMM;
            alu_control = ALU_ADD;
         end
         S_MEMADR: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_IMM;
            alu_control = ALU_ADD;
         end
         S_MEMREAD: begin
            mem_read = 1'b1;
            adr_src  = ADR_ALUOUT;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            result_src = RES_MDR;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            mem_write  = 1'b1;
            adr_src    = ADR_ALUOUT;
            instr_done = mem_ready;
         end
         S_EXECR: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_RS2;
            alu_control = dec_alu;
         end
         S_EXECI: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_IMM;
            alu_control = dec_alu;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            result_src = RES_ALUOUT;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_RS2;
            alu_control = dec_alu;
            result_src  = RES_ALUOUT;
            pc_write    = zero;
            instr_done  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences, traps,
// memory timeout boundary and asynchronous reset mid-write.
module tb_multicycle_controller;
   import riscv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [3:0] alu_control;
   logic       instr_done, illegal, bus_error;
   logic [3:0] state;
   logic [16:0] strobes;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.TIMEOUT_CYCLES(16), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .result_src(result_src), .alu_control(alu_control), .instr_done(instr_done),
      .illegal(illegal), .bus_error(bus_error), .state(state)
   );

   assign strobes = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
                     alu_src_a, alu_src_b, result_src, alu_control, instr_done};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // leaves the DUT in its first FETCH cycle
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      check("rst_hold_state", state, S_RESET);
      tick();
      check("rst_to_fetch", state, S_FETCH);
   endtask

   // from FETCH with mem_ready=1: R/I instruction, check EXEC selects and return
   task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [3:0] exp_alu, input logic [1:0] exp_b);
      opcode = op; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
      tick();
      tick();
      check({tag, "_exec"}, {state, alu_src_a, alu_src_b, alu_control},
            {(op == OP_RTYPE) ? S_EXECR : S_EXECI, 2'b10, exp_b, exp_alu});
      tick();
      check({tag, "_wb"}, {state, reg_write, instr_done}, {S_ALUWB, 2'b11});
      tick();
      check({tag, "_back"}, state, S_FETCH);
   endtask

   task automatic trap_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7);
      opcode = op; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
      tick();
      check({tag, "_decode"}, state, S_DECODE);
      tick();
      check({tag, "_trap"}, {state, illegal, bus_error}, {S_TRAP, 2'b10});
      do_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, dones, ncyc;
      rst = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_state", state, S_RESET);
      check("reset_strobes", strobes, 17'h0);
      check("reset_flags", {illegal, bus_error}, 2'b00);
      rst = 1'b0;
      tick();
      check("reset_exit", state, S_FETCH);

      // add x3,x1,x2 with zero-wait memory
      opcode = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
      #1;
      check("add_fetch_strobe", {ir_write, pc_write, mem_read, instr_done}, 4'b1110);
      check("add_fetch_sel", {adr_src, alu_src_a, alu_src_b, result_src, alu_control},
            {1'b0, 2'b00, 2'b10, 2'b10, 4'b0010});
      dones = 0;
      tick();
      check("add_decode", {state, alu_src_a, alu_src_b, alu_control}, {S_DECODE, 2'b01, 2'b01, 4'b0010});
      dones += int'(instr_done);
      tick();
      check("add_execr", {state, alu_src_a, alu_src_b, alu_control, reg_write},
            {S_EXECR, 2'b10, 2'b00, 4'b0010, 1'b0});
      dones += int'(instr_done);
      tick();
      check("add_aluwb", {state, reg_write, result_src, instr_done}, {S_ALUWB, 1'b1, 2'b00, 1'b1});
      check("add_done_early", dones, 0);
      tick();
      check("add_next", {state, reg_write}, {S_FETCH, 1'b0});

      run_alu("sub",  OP_RTYPE, 3'b000, 1'b1, 4'b0110, 2'b00);
      run_alu("slt",  OP_RTYPE, 3'b010, 1'b0, 4'b0111, 2'b00);
      run_alu("and",  OP_RTYPE, 3'b111, 1'b0, 4'b0000, 2'b00);
      run_alu("addi", OP_ITYPE, 3'b000, 1'b0, 4'b0010, 2'b01);
      run_alu("xori", OP_ITYPE, 3'b100, 1'b0, 4'b0011, 2'b01);
      run_alu("ori",  OP_ITYPE, 3'b110, 1'b0, 4'b0001, 2'b01);

      // lw with 3 wait cycles in MEMREAD: 8 cycles total
      opcode = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
      ncyc = 1;
      tick(); ncyc++;
      check("lw_decode", state, S_DECODE);
      mem_ready = 1'b0;
      tick(); ncyc++;
      check("lw_memadr", {state, alu_src_a, alu_src_b, alu_control}, {S_MEMADR, 2'b10, 2'b01, 4'b0010});
      tick(); ncyc++;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (state != S_MEMREAD || {mem_read, adr_src, reg_write} != 3'b110) bad++;
         tick(); ncyc++;
      end
      check("lw_memread_wait", bad, 0);
      mem_ready = 1'b1;
      #1;
      check("lw_memread_last", {state, mem_read, adr_src}, {S_MEMREAD, 2'b11});
      tick(); ncyc++;
      check("lw_memwb", {state, reg_write, result_src, instr_done}, {S_MEMWB, 1'b1, 2'b01, 1'b1});
      tick();
      check("lw_cycles", ncyc, 8);
      check("lw_next", state, S_FETCH);

      // sw, zero-wait
      opcode = OP_STORE;
      tick(); tick(); tick();
      check("sw_memwrite", {state, mem_write, adr_src, instr_done}, {S_MEMWRITE, 3'b111});
      tick();
      check("sw_next", state, S_FETCH);

      // beq taken / not taken
      opcode = OP_BRANCH; funct3 = 3'b000; zero = 1'b1;
      tick(); tick();
      check("beq_t", {state, pc_write, instr_done, alu_control, alu_src_a, alu_src_b},
            {S_BEQ, 2'b11, 4'b0110, 2'b10, 2'b00});
      tick();
      check("beq_t_next", state, S_FETCH);
      zero = 1'b0;
      tick(); tick();
      check("beq_nt", {state, pc_write, instr_done}, {S_BEQ, 2'b01});
      tick();
      check("beq_nt_next", state, S_FETCH);

      // unsupported opcode: trap holds with strobes low
      opcode = 7'b1111111;
      tick(); tick();
      check("ill_trap", {state, illegal, bus_error}, {S_TRAP, 2'b10});
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         #1;
         if (state != S_TRAP || strobes != 17'h0 || illegal != 1'b1) bad++;
         tick();
      end
      check("ill_hold", bad, 0);
      rst = 1'b1;
      #1;
      check("ill_async_clear", {state, illegal}, {S_RESET, 1'b0});
      do_reset();

      trap_case("r_f3_001",  OP_RTYPE,  3'b001, 1'b0);
      trap_case("i_f7b5",    OP_ITYPE,  3'b110, 1'b1);
      trap_case("br_f3_001", OP_BRANCH, 3'b001, 1'b0);

      // memory timeout: 16 wait cycles in FETCH then TRAP
      mem_ready = 1'b0; opcode = OP_STORE; funct3 = 3'b010; funct7b5 = 1'b0;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (state != S_FETCH || bus_error) bad++;
         tick();
      end
      check("to_waits", bad, 0);
      check("to_trap", {state, bus_error, illegal}, {S_TRAP, 2'b10});
      check("to_strobes", strobes, 17'h0);
      do_reset();
      check("to_cleared", bus_error, 1'b0);

      // ready on the 16th wait cycle wins
      for (int i = 0; i < 15; i++) tick();
      mem_ready = 1'b1;
      #1;
      check("to_edge_fetch", {state, ir_write}, {S_FETCH, 1'b1});
      tick();
      check("to_edge_decode", {state, bus_error}, {S_DECODE, 1'b0});

      // reset mid-MEMWRITE while memory stalls
      mem_ready = 1'b0;
      tick();
      tick();
      check("rmw_memwrite", {state, mem_write, instr_done}, {S_MEMWRITE, 2'b10});
      #1;
      rst = 1'b1;
      #1;
      check("rmw_async_drop", {state, mem_write}, {S_RESET, 1'b0});
      @(posedge clk);
      #2;
      rst = 1'b0;
      check("rmw_reset", {state, mem_write}, {S_RESET, 1'b0});
      tick();
      check("rmw_fetch", {state, mem_write}, {S_FETCH, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
